// File: rtl/pf_iod_rx_lane_trainer_if.sv
// rtl/pf_iod_rx_lane_trainer_if.sv - IOD receive-lane training signal bundle
interface pf_iod_rx_lane_trainer_if;
  logic       TRAIN_START;
  logic [3:0] RX_DATA_0;
  logic       DELAY_LINE_OUT_OF_RANGE_0;
  logic       RX_BIT_SLIP_0;
  logic       DELAY_LINE_LOAD_0;
  logic       DELAY_LINE_MOVE_0;
  logic       DELAY_LINE_DIRECTION_0;
  logic       TRAIN_BUSY;
  logic       TRAIN_DONE;
  logic       TRAIN_FAIL;
  logic [1:0] SLIP_COUNT;
  logic [7:0] TAP_COUNT;
  logic [7:0] ERR_COUNT;

  modport master (
    input  TRAIN_START, RX_DATA_0, DELAY_LINE_OUT_OF_RANGE_0,
    output RX_BIT_SLIP_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
    output TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL, SLIP_COUNT, TAP_COUNT, ERR_COUNT
  );

  modport slave (
    output TRAIN_START, RX_DATA_0, DELAY_LINE_OUT_OF_RANGE_0,
    input  RX_BIT_SLIP_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
    input  TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL, SLIP_COUNT, TAP_COUNT, ERR_COUNT
  );
endinterface

// File: rtl/pf_iod_rx_lane_trainer.sv
// rtl/pf_iod_rx_lane_trainer.sv - word alignment and delay-tap training for a 4:1 IOD lane
module pf_iod_rx_lane_trainer #(
  parameter logic [3:0] TRAIN_PATTERN = 4'b1100,
  parameter int         MATCH_COUNT   = 16,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         MAX_TAPS      = 127
) (
  input logic                      FAB_CLK,
  input logic                      ARST_N,
  pf_iod_rx_lane_trainer_if.master lane
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_SLIP, S_MOVE, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
  localparam logic [7:0] TAP_LIMIT   = 8'(MAX_TAPS);

  state_t     state, state_n;
  logic [7:0] settle_cnt, settle_cnt_n;
  logic [7:0] match_cnt, match_cnt_n;
  logic [7:0] tap_cnt, tap_cnt_n;
  logic [7:0] err_cnt, err_cnt_n;
  logic [1:0] slip_cnt, slip_cnt_n;
  logic       after_move, after_move_n;
  logic       word_ok;

  assign word_ok = (lane.RX_DATA_0 == TRAIN_PATTERN);

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state      <= S_IDLE;
      settle_cnt <= 8'd0;
      match_cnt  <= 8'd0;
      tap_cnt    <= 8'd0;
      err_cnt    <= 8'd0;
      slip_cnt   <= 2'd0;
      after_move <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      match_cnt  <= match_cnt_n;
      tap_cnt    <= tap_cnt_n;
      err_cnt    <= err_cnt_n;
      slip_cnt   <= slip_cnt_n;
      after_move <= after_move_n;
    end
  end

  always_comb begin
    state_n      = state;
    settle_cnt_n = 8'd0;
    match_cnt_n  = 8'd0;
    tap_cnt_n    = tap_cnt;
    err_cnt_n    = err_cnt;
    slip_cnt_n   = slip_cnt;
    after_move_n = after_move;
    case (state)
      S_IDLE: ;
      S_LOAD: begin
        slip_cnt_n   = 2'd0;
        tap_cnt_n    = 8'd0;
        err_cnt_n    = 8'd0;
        after_move_n = 1'b0;
        state_n      = S_SETTLE;
      end
      S_SETTLE: begin
        // The end stop only matters once the tap has actually been moved.
        if (after_move && lane.DELAY_LINE_OUT_OF_RANGE_0)
          state_n = S_FAIL;
        else if (settle_cnt == SETTLE_LAST)
          state_n = S_CHECK;
        else
          settle_cnt_n = settle_cnt + 8'd1;
      end
      S_CHECK: begin
        if (!word_ok)
          state_n = S_SLIP;
        else if (match_cnt == MATCH_LAST)
          state_n = S_LOCKED;
        else
          match_cnt_n = match_cnt + 8'd1;
      end
      S_SLIP: begin
        slip_cnt_n   = slip_cnt + 2'd1;
        after_move_n = 1'b0;
        state_n      = (slip_cnt == 2'd3) ? S_MOVE : S_SETTLE;
      end
      S_MOVE: begin
        tap_cnt_n    = tap_cnt + 8'd1;
        after_move_n = 1'b1;
        state_n      = (tap_cnt_n == TAP_LIMIT) ? S_FAIL : S_SETTLE;
      end
      S_LOCKED: begin
        if (!word_ok && err_cnt != 8'hff)
          err_cnt_n = err_cnt + 8'd1;
      end
      S_FAIL: ;
      default: state_n = S_IDLE;
    endcase
    if (lane.TRAIN_START)
      state_n = S_LOAD;
  end

  // Pulses and status levels are registered copies of the current state,
  // so a pulse always lasts exactly one cycle even across a restart.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      lane.RX_BIT_SLIP_0          <= 1'b0;
      lane.DELAY_LINE_LOAD_0      <= 1'b0;
      lane.DELAY_LINE_MOVE_0      <= 1'b0;
      lane.DELAY_LINE_DIRECTION_0 <= 1'b0;
      lane.TRAIN_BUSY             <= 1'b0;
      lane.TRAIN_DONE             <= 1'b0;
      lane.TRAIN_FAIL             <= 1'b0;
    end else begin
      lane.RX_BIT_SLIP_0          <= (state == S_SLIP);
      lane.DELAY_LINE_LOAD_0      <= (state == S_LOAD);
      lane.DELAY_LINE_MOVE_0      <= (state == S_MOVE);
      lane.DELAY_LINE_DIRECTION_0 <= (state == S_MOVE);
      lane.TRAIN_BUSY             <= (state inside {S_LOAD, S_SETTLE, S_CHECK, S_SLIP, S_MOVE});
      lane.TRAIN_DONE             <= (state == S_LOCKED);
      lane.TRAIN_FAIL             <= (state == S_FAIL);
    end
  end

  assign lane.SLIP_COUNT = slip_cnt;
  assign lane.TAP_COUNT  = tap_cnt;
  assign lane.ERR_COUNT  = err_cnt;
endmodule

// File: tb/tb_pf_iod_rx_lane_trainer.sv
// tb/tb_pf_iod_rx_lane_trainer.sv - randomized lane-model bench for pf_iod_rx_lane_trainer
module tb_pf_iod_rx_lane_trainer;
  localparam logic [3:0] PAT   = 4'b1100;
  localparam int         S     = 8;
  localparam int         M     = 16;
  localparam int         MAXT  = 127;
  localparam int         NEVER = 1000;
  localparam int         BUDGET = 20000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pf_iod_rx_lane_trainer_if lane_if ();

  pf_iod_rx_lane_trainer #(
    .TRAIN_PATTERN(PAT), .MATCH_COUNT(M), .SETTLE_CYCLES(S), .MAX_TAPS(MAXT)
  ) dut (
    .FAB_CLK(clk),
    .ARST_N (rst_n),
    .lane   (lane_if.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
    logic [3:0] r;
    r = w;
    for (int i = 0; i < (n % 4); i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  function automatic logic [31:0] outs();
    return {7'd0, lane_if.RX_BIT_SLIP_0, lane_if.DELAY_LINE_LOAD_0, lane_if.DELAY_LINE_MOVE_0,
            lane_if.DELAY_LINE_DIRECTION_0, lane_if.TRAIN_BUSY, lane_if.TRAIN_DONE,
            lane_if.TRAIN_FAIL, lane_if.SLIP_COUNT, lane_if.TAP_COUNT, lane_if.ERR_COUNT};
  endfunction

  // Lane model: delay tap, accumulated bit rotation, and the word the IOD presents.
  int         m_tap = 0, m_rot = 0, good_tap = NEVER, oor_tap = NEVER;
  logic [3:0] base = PAT;
  logic [3:0] noise;
  logic [3:0] force_word = 4'd0;
  bit         force_en = 0;
  int         n_slip = 0, n_move = 0, n_load = 0, n_excl = 0;
  int         cyc = 0, last_slip = -1, slip_gap = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (int'(lane_if.RX_BIT_SLIP_0) + int'(lane_if.DELAY_LINE_MOVE_0) +
        int'(lane_if.DELAY_LINE_LOAD_0) > 1 || (lane_if.TRAIN_DONE && lane_if.TRAIN_FAIL))
      n_excl++;
    if (lane_if.DELAY_LINE_LOAD_0) begin
      m_tap = 0;
      n_load++;
    end
    if (lane_if.DELAY_LINE_MOVE_0) begin
      n_move++;
      if (lane_if.DELAY_LINE_DIRECTION_0) m_tap++;
    end
    if (lane_if.RX_BIT_SLIP_0) begin
      n_slip++;
      m_rot = (m_rot + 1) % 4;
      if (last_slip >= 0) slip_gap = cyc - last_slip - 1;
      last_slip = cyc;
    end
    noise = 4'($urandom);
    if (noise == PAT) noise = ~PAT;
    if (force_en)             lane_if.RX_DATA_0 = force_word;
    else if (m_tap >= good_tap) lane_if.RX_DATA_0 = rotl(base, m_rot);
    else                      lane_if.RX_DATA_0 = noise;
    lane_if.DELAY_LINE_OUT_OF_RANGE_0 = (m_tap >= oor_tap);
  end

  task automatic setup_lane(input int g, input int need, input int oor);
    good_tap = g;
    oor_tap  = oor;
    base     = rotl(PAT, (4 - ((m_rot + need) % 4)) % 4);
    n_slip = 0; n_move = 0; n_load = 0;
    last_slip = -1; slip_gap = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    lane_if.TRAIN_START = 1'b1;
    @(posedge clk);
    #1 lane_if.TRAIN_START = 1'b0;
  endtask

  task automatic wait_end(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(lane_if.TRAIN_DONE || lane_if.TRAIN_FAIL) && lat < BUDGET);
  endtask

  task automatic run_train(input string tag, input int g, input int need, input int oor,
                           output int lat);
    int fail_tap, exp_tap, exp_slc;
    bit exp_fail;
    setup_lane(g, need, oor);
    pulse_start();
    wait_end(lat);
    check({tag, "_timeout"}, lat < BUDGET, 1);
    repeat (2) @(posedge clk);
    #1;
    fail_tap = (oor < MAXT) ? oor : MAXT;
    exp_fail = (fail_tap <= g);
    exp_tap  = exp_fail ? fail_tap : g;
    exp_slc  = exp_fail ? 0 : need;
    check({tag, "_done"},  lane_if.TRAIN_DONE, !exp_fail);
    check({tag, "_fail"},  lane_if.TRAIN_FAIL, exp_fail);
    check({tag, "_busy"},  lane_if.TRAIN_BUSY, 0);
    check({tag, "_tap"},   lane_if.TAP_COUNT, exp_tap);
    check({tag, "_slipc"}, lane_if.SLIP_COUNT, exp_slc);
    check({tag, "_slips"}, n_slip, 4 * exp_tap + exp_slc);
    check({tag, "_moves"}, n_move, exp_tap);
    check({tag, "_loads"}, n_load, 1);
    check({tag, "_err"},   lane_if.ERR_COUNT, 0);
  endtask

  task automatic inject_bad(input int n);
    @(posedge clk);
    #2 force_word = 4'b0000;
    force_en = 1;
    repeat (n) @(posedge clk);
    #2 force_en = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, g, need, oor, k;
    lane_if.TRAIN_START = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lane_if.TRAIN_START = i[0];
    end
    #1 check("rst_hold_outs", outs(), 0);
    @(negedge clk);
    lane_if.TRAIN_START = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("rst_idle_outs", outs(), 0);

    run_train("aligned", 0, 0, NEVER, lat);
    check("aligned_latency", lat, 1 + S + M + 1);

    inject_bad(3);
    check("err3_count", lane_if.ERR_COUNT, 3);
    check("err3_done", lane_if.TRAIN_DONE, 1);
    inject_bad(300);
    check("err300_sat", lane_if.ERR_COUNT, 255);
    check("err300_done", lane_if.TRAIN_DONE, 1);

    run_train("rotated", 0, 2, NEVER, lat);
    check("rotated_gap", slip_gap, 1 + S);

    run_train("oor5", NEVER, 0, 5, lat);
    run_train("maxtaps", NEVER, 0, NEVER, lat);

    for (int i = 0; i < 6; i++) begin
      g    = $urandom_range(0, 5);
      need = $urandom_range(0, 3);
      oor  = ($urandom_range(0, 1) == 1) ? NEVER : int'($urandom_range(1, 6));
      run_train($sformatf("rnd%0d", i), g, need, oor, lat);
    end

    setup_lane(3, 0, NEVER);
    pulse_start();
    k = 0;
    while (lane_if.TAP_COUNT != 8'd3 && k < BUDGET) begin
      @(posedge clk);
      #1 k++;
    end
    check("midchk_reach", k < BUDGET, 1);
    repeat (S + 4) @(posedge clk);
    n_load = 0;
    pulse_start();
    check("midchk_load_e0", lane_if.DELAY_LINE_LOAD_0, 0);
    @(posedge clk);
    #1;
    check("midchk_load_e1", lane_if.DELAY_LINE_LOAD_0, 1);
    check("midchk_tap_clr", lane_if.TAP_COUNT, 0);
    check("midchk_slip_clr", lane_if.SLIP_COUNT, 0);
    check("midchk_busy", lane_if.TRAIN_BUSY, 1);
    @(posedge clk);
    #1 check("midchk_load_e2", lane_if.DELAY_LINE_LOAD_0, 0);
    wait_end(lat);
    check("midchk_relock", lane_if.TRAIN_DONE, 1);
    check("midchk_retap", lane_if.TAP_COUNT, 3);
    check("midchk_loads", n_load, 1);

    setup_lane(NEVER, 0, NEVER);
    pulse_start();
    k = 0;
    while (n_slip == 0 && k < 500) begin
      @(posedge clk);
      #1 k++;
    end
    check("rstmid_slip_seen", n_slip > 0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rstmid_outs", outs(), 0);
    n_slip = 0; n_move = 0; n_load = 0;
    repeat (20) @(posedge clk);
    #1 check("rstmid_pulses", n_slip + n_move + n_load, 0);
    check("rstmid_outs_hold", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    check("exclusive", n_excl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
